// File: rtl/game_pkg.sv
// Shared timer types and defaults for the maze round timer and HUD path.
package game_pkg;

  localparam int DEFAULT_SEC_W = 10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    PAUSE   = 3'd2,
    TIMEOUT = 3'd3,
    WIN     = 3'd4
  } timer_state_t;

  // A new round may only be launched when no round is in progress.
  function automatic logic accepts_start(input timer_state_t s);
    return (s == IDLE) || (s == TIMEOUT) || (s == WIN);
  endfunction

endpackage

// File: rtl/round_timer_ctrl_sec_tick_gen.sv
// Prescaler: divides the system clock into one-second ticks; holds its count while disabled.
module sec_tick_gen #(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic clk,
  input  logic rst_in,
  input  logic en_in,
  input  logic clr_in,
  output logic tick_out
);

  localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] count;

  // Combinational so the top can act on the tick in the same edge that wraps the count.
  assign tick_out = en_in && (count == LAST);

  // NOTE: sequential state uses non-blocking assignments and an async active-low reset.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      count <= '0;
    end else if (clr_in) begin
      count <= '0;
    end else if (en_in) begin
      count <= (count == LAST) ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/round_timer_ctrl.sv
// Round countdown controller: start/pause/abort/goal FSM plus remaining and elapsed second counters.
module round_timer_ctrl
  import game_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int SEC_W         = DEFAULT_SEC_W
) (
  input  logic             clk_100mhz_in,
  input  logic             rst_in,
  input  logic [SEC_W-1:0] max_sec_in,
  input  logic             start_in,
  input  logic             pause_in,
  input  logic             goal_in,
  input  logic             abort_in,
  output logic [SEC_W-1:0] sec_left_out,
  output logic [SEC_W-1:0] sec_elapsed_out,
  output logic [2:0]       state_out,
  output logic             running_out,
  output logic             sec_tick_out,
  output logic             timeout_out,
  output logic             win_out
);

  localparam logic [SEC_W-1:0] SEC_MAX = {SEC_W{1'b1}};

  timer_state_t state_q;
  logic         tick;
  logic         start_ok;
  logic         presc_clr;

  assign start_ok  = start_in && !abort_in && accepts_start(state_q);
  assign presc_clr = abort_in || start_ok;
  assign state_out = state_q;

  sec_tick_gen #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_sec_tick_gen (
    .clk      (clk_100mhz_in),
    .rst_in   (rst_in),
    .en_in    (state_q == RUN),
    .clr_in   (presc_clr),
    .tick_out (tick)
  );

  always_ff @(posedge clk_100mhz_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q         <= IDLE;
      running_out     <= 1'b0;
      sec_left_out    <= '0;
      sec_elapsed_out <= '0;
      sec_tick_out    <= 1'b0;
      timeout_out     <= 1'b0;
      win_out         <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low each edge so they can never stick for more than one cycle.
      sec_tick_out <= 1'b0;
      timeout_out  <= 1'b0;
      win_out      <= 1'b0;

      if (abort_in) begin
        state_q         <= IDLE;
        running_out     <= 1'b0;
        sec_left_out    <= '0;
        sec_elapsed_out <= '0;
      end else begin
        case (state_q)
          IDLE, TIMEOUT, WIN: begin
            if (start_in) begin
              sec_left_out    <= max_sec_in;
              sec_elapsed_out <= '0;
              if (max_sec_in != '0) begin
                state_q     <= RUN;
                running_out <= 1'b1;
              end else begin
                state_q     <= TIMEOUT;
                running_out <= 1'b0;
                timeout_out <= 1'b1;
              end
            end
          end

          RUN: begin
            if (goal_in) begin
              state_q     <= WIN;
              running_out <= 1'b0;
              win_out     <= 1'b1;
            end else if (tick) begin
              sec_tick_out    <= 1'b1;
              sec_elapsed_out <= (sec_elapsed_out == SEC_MAX) ? SEC_MAX
                                                              : sec_elapsed_out + SEC_W'(1);
              if (sec_left_out <= SEC_W'(1)) begin
                // Final second: expiry outranks a simultaneous pause.
                sec_left_out <= '0;
                state_q      <= TIMEOUT;
                running_out  <= 1'b0;
                timeout_out  <= 1'b1;
              end else begin
                sec_left_out <= sec_left_out - SEC_W'(1);
                if (pause_in) begin
                  state_q     <= PAUSE;
                  running_out <= 1'b0;
                end
              end
            end else if (pause_in) begin
              state_q     <= PAUSE;
              running_out <= 1'b0;
            end
          end

          PAUSE: begin
            if (goal_in) begin
              state_q <= WIN;
              win_out <= 1'b1;
            end else if (pause_in) begin
              state_q     <= RUN;
              running_out <= 1'b1;
            end
          end

          default: begin
            state_q     <= IDLE;
            running_out <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Directed bench for round_timer_ctrl with a 4-cycle second.
module tb_round_timer_ctrl;

  localparam int TPS   = 4;
  localparam int SEC_W = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [SEC_W-1:0] max_sec = '0;
  logic             start = 1'b0, pause = 1'b0, goal = 1'b0, abort = 1'b0;
  logic [SEC_W-1:0] sec_left, sec_elapsed;
  logic [2:0]       state;
  logic             running, sec_tick, timeout, win;

  int n_checks = 0;
  int n_errors = 0;

  round_timer_ctrl #(.TICKS_PER_SEC(TPS), .SEC_W(SEC_W)) dut (
    .clk_100mhz_in   (clk),
    .rst_in          (rst_n),
    .max_sec_in      (max_sec),
    .start_in        (start),
    .pause_in        (pause),
    .goal_in         (goal),
    .abort_in        (abort),
    .sec_left_out    (sec_left),
    .sec_elapsed_out (sec_elapsed),
    .state_out       (state),
    .running_out     (running),
    .sec_tick_out    (sec_tick),
    .timeout_out     (timeout),
    .win_out         (win)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_round(input int m);
    max_sec = SEC_W'(m);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    cyc(2);
    check("rst_state", 32'(state), 0);
    check("rst_left", 32'(sec_left), 0);
    check("rst_elapsed", 32'(sec_elapsed), 0);
    check("rst_pulses", 32'({running, sec_tick, timeout, win}), 0);
    rst_n = 1'b1;
    cyc(2);
    check("idle_state", 32'(state), 0);

    // Countdown from 3 to timeout
    start_round(3);
    check("t1_state", 32'(state), 1);
    check("t1_running", 32'(running), 1);
    check("t1_left0", 32'(sec_left), 3);
    cyc(3);
    check("t1_notick", 32'(sec_tick), 0);
    check("t1_left_hold", 32'(sec_left), 3);
    cyc(1);
    check("t1_tick1", 32'(sec_tick), 1);
    check("t1_left1", 32'(sec_left), 2);
    check("t1_elapsed1", 32'(sec_elapsed), 1);
    cyc(1);
    check("t1_tick_pulse", 32'(sec_tick), 0);
    cyc(3);
    check("t1_left2", 32'(sec_left), 1);
    check("t1_tick2", 32'(sec_tick), 1);
    cyc(4);
    check("t1_left3", 32'(sec_left), 0);
    check("t1_timeout", 32'(timeout), 1);
    check("t1_state_to", 32'(state), 3);
    check("t1_elapsed3", 32'(sec_elapsed), 3);
    check("t1_running_off", 32'(running), 0);
    cyc(1);
    check("t1_timeout_pulse", 32'(timeout), 0);
    check("t1_hold_elapsed", 32'(sec_elapsed), 3);

    // Pause keeps the fractional second
    start_round(5);
    cyc(4);
    check("t2_left1", 32'(sec_left), 4);
    cyc(1);
    pause = 1'b1;
    cyc(1);
    pause = 1'b0;
    check("t2_paused", 32'(state), 2);
    check("t2_running", 32'(running), 0);
    cyc(20);
    check("t2_frozen_left", 32'(sec_left), 4);
    check("t2_frozen_tick", 32'(sec_tick), 0);
    pause = 1'b1;
    cyc(1);
    pause = 1'b0;
    check("t2_resumed", 32'(state), 1);
    check("t2_resume_notick", 32'(sec_tick), 0);
    cyc(1);
    check("t2_notick_r1", 32'(sec_tick), 0);
    cyc(1);
    check("t2_tick_r2", 32'(sec_tick), 1);
    check("t2_left_r2", 32'(sec_left), 3);
    check("t2_elapsed_r2", 32'(sec_elapsed), 2);

    // Abort, then goal coinciding with the second tick
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    check("t3_abort_state", 32'(state), 0);
    check("t3_abort_left", 32'(sec_left), 0);
    start_round(5);
    cyc(4);
    check("t3_left1", 32'(sec_left), 4);
    cyc(3);
    goal = 1'b1;
    cyc(1);
    goal = 1'b0;
    check("t3_win_state", 32'(state), 4);
    check("t3_win_pulse", 32'(win), 1);
    check("t3_win_left", 32'(sec_left), 4);
    check("t3_win_elapsed", 32'(sec_elapsed), 1);
    check("t3_win_notick", 32'(sec_tick), 0);
    cyc(1);
    check("t3_win_once", 32'(win), 0);
    check("t3_win_hold", 32'(state), 4);

    // Zero-length round
    start_round(0);
    check("t4_state", 32'(state), 3);
    check("t4_timeout", 32'(timeout), 1);
    check("t4_running", 32'(running), 0);
    cyc(1);
    check("t4_timeout_once", 32'(timeout), 0);

    // Start ignored in RUN, abort clears everything
    start_round(5);
    cyc(12);
    check("t5_left", 32'(sec_left), 2);
    cyc(1);
    start_round(7);
    check("t5_start_ignored", 32'(sec_left), 2);
    check("t5_still_run", 32'(state), 1);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    check("t5_abort_state", 32'(state), 0);
    check("t5_abort_cnt", 32'({sec_left, sec_elapsed}), 0);
    check("t5_abort_pulses", 32'({running, sec_tick, timeout, win}), 0);
    cyc(8);
    check("t5_idle_quiet", 32'({sec_left, sec_tick}), 0);

    // Asynchronous reset between edges
    start_round(5);
    cyc(2);
    check("t6_pre_left", 32'(sec_left), 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_state", 32'(state), 0);
    check("t6_async_left", 32'(sec_left), 0);
    check("t6_async_running", 32'(running), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);

    // Full-range round
    start_round(1023);
    check("t7_left_max", 32'(sec_left), 1023);
    cyc(4 * 1022);
    check("t7_left1", 32'(sec_left), 1);
    check("t7_elapsed1022", 32'(sec_elapsed), 1022);
    cyc(4);
    check("t7_timeout", 32'(timeout), 1);
    check("t7_elapsed_max", 32'(sec_elapsed), 1023);
    check("t7_left0", 32'(sec_left), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
